// File: rtl/note_arbiter.sv
// note_arbiter: debounces eight piano keys and picks the note that sounds.
// A single held key plays continuously. Several held keys take turns
// round-robin, one time slot each. The chosen period is handed to the tone
// divider over a valid/ready handshake.
//
// state | meaning
// IDLE  | no key held, divider disabled
// LOAD  | offering tone_period to the divider, waiting for tone_ready
// PLAY  | divider enabled, slot timer running
module note_arbiter #(
  parameter int DEB_CYCLES  = 500000,
  parameter int SLOT_CYCLES = 5000000,
  parameter int PW          = 18
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic [7:0]    keys,
  output logic [7:0]    active_keys,
  output logic [PW-1:0] tone_period,
  output logic          tone_valid,
  input  logic          tone_ready,
  output logic          tone_on,
  output logic [2:0]    note_idx
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(SLOT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t        state, state_d;
  logic [7:0]    sync1, sync2;
  logic [DW-1:0] cnt [8];
  logic [TW-1:0] timer;
  logic [2:0]    cur, cur_d, ptr;
  logic          reload;
  logic          expiry;
  logic [7:0]    others;

  // First set bit of mask, scanning upward from start and wrapping at 7.
  function automatic logic [2:0] sel(input logic [2:0] start, input logic [7:0] mask);
    logic [2:0] r;
    logic [2:0] idx;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (mask[idx]) r = idx;
    end
    return r;
  endfunction

  // Divider periods for Do4..Do5.
  function automatic logic [PW-1:0] period_of(input logic [2:0] i);
    logic [PW-1:0] p;
    case (i)
      3'd0:    p = PW'(191113);
      3'd1:    p = PW'(170263);
      3'd2:    p = PW'(151687);
      3'd3:    p = PW'(143173);
      3'd4:    p = PW'(127553);
      3'd5:    p = PW'(113637);
      3'd6:    p = PW'(101239);
      default: p = PW'(95557);
    endcase
    return p;
  endfunction

  assign expiry = (timer == TW'(SLOT_CYCLES - 1));

  // Two-flop synchroniser for the asynchronous key levels.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: flip only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      active_keys <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == active_keys[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          active_keys[i] <= ~active_keys[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and next-note selection; reload marks a new period to offer.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    reload  = 1'b0;
    others  = active_keys & ~(8'd1 << cur);
    case (state)
      IDLE: begin
        if (active_keys != 8'd0) begin
          cur_d   = sel(ptr, active_keys);
          reload  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tone_ready) state_d = (active_keys != 8'd0) ? PLAY : IDLE;
      end
      PLAY: begin
        if (active_keys == 8'd0) begin
          state_d = IDLE;
        end else if (!active_keys[cur]) begin
          cur_d   = sel(ptr, active_keys);
          reload  = 1'b1;
          state_d = LOAD;
        end else if (expiry && others != 8'd0) begin
          cur_d   = sel(ptr, others);
          reload  = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    tone_valid = (state == LOAD);
    tone_on    = (state == PLAY);
  end

  // Note datapath and slot timer; the period is frozen while LOAD waits.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cur         <= 3'd0;
      ptr         <= 3'd0;
      note_idx    <= 3'd0;
      tone_period <= '0;
      timer       <= '0;
    end else begin
      cur <= cur_d;
      if (reload) tone_period <= period_of(cur_d);
      if (state == LOAD && tone_ready) begin
        note_idx <= cur;
        ptr      <= cur + 3'd1;
      end
      if (state != PLAY || expiry) timer <= '0;
      else                         timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_note_arbiter.sv
// Bench for note_arbiter with short debounce and slot lengths.
// Expected handshakes are queued by the stimulus; a monitor pops them.
module tb_note_arbiter;

  localparam int PW = 18;

  logic          clk;
  logic          rst;
  logic [7:0]    keys;
  logic [7:0]    active_keys;
  logic [PW-1:0] tone_period;
  logic          tone_valid;
  logic          tone_ready;
  logic          tone_on;
  logic [2:0]    note_idx;

  typedef struct {
    logic [PW-1:0] period;
    logic [2:0]    idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   hs_count;

  note_arbiter #(.DEB_CYCLES(4), .SLOT_CYCLES(16), .PW(PW)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .keys       (keys),
    .active_keys(active_keys),
    .tone_period(tone_period),
    .tone_valid (tone_valid),
    .tone_ready (tone_ready),
    .tone_on    (tone_on),
    .note_idx   (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n;
    n = 0;
    while (!tone_valid && n < limit) begin
      tick();
      n++;
    end
    chk(name, int'(tone_valid), 1);
  endtask

  task automatic wait_on(input int limit, input string name);
    int n;
    n = 0;
    while (!tone_on && n < limit) begin
      tick();
      n++;
    end
    chk(name, int'(tone_on), 1);
  endtask

  // Monitor: every accepted handshake must match the head of the queue.
  task automatic monitor_loop();
    exp_t       e;
    logic       pend;
    logic [2:0] pidx;
    pend = 1'b0;
    pidx = 3'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("hs_note_idx", int'(note_idx), int'(pidx));
        pend = 1'b0;
      end
      if (tone_valid && tone_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake actual period=%0d expected none", tone_period);
        end else begin
          e = exp_q.pop_front();
          chk("hs_period", int'(tone_period), int'(e.period));
          pend = 1'b1;
          pidx = e.idx;
        end
      end
    end
  endtask

  initial begin
    int   seen;
    int   bad_on;
    int   bad_valid;
    int   len;
    logic [2:0] arp [7];

    checks     = 0;
    errors     = 0;
    hs_count   = 0;
    rst        = 1'b1;
    keys       = 8'h00;
    tone_ready = 1'b0;
    fork
      monitor_loop();
    join_none

    // reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_active_keys", int'(active_keys), 0);
    chk("rst_tone_period", int'(tone_period), 0);
    chk("rst_tone_valid",  int'(tone_valid), 0);
    chk("rst_tone_on",     int'(tone_on), 0);
    chk("rst_note_idx",    int'(note_idx), 0);

    // 3-clock glitch on key 2 must be filtered
    keys = 8'h04;
    tick(); tick(); tick();
    keys = 8'h00;
    seen = 0;
    repeat (10) begin
      tick();
      if (active_keys != 8'h00) seen = 1;
    end
    chk("glitch_filtered", seen, 0);

    // key 2 held: active after 6 clocks, valid one clock later
    keys = 8'h04;
    exp_q.push_back('{PW'(151687), 3'd2});
    repeat (5) tick();
    chk("deb_not_yet", int'(active_keys), 0);
    tick();
    chk("deb_flip", int'(active_keys), 8'h04);
    chk("valid_not_yet", int'(tone_valid), 0);
    tick();
    chk("valid_after_1clk", int'(tone_valid), 1);
    chk("first_period", int'(tone_period), 151687);
    tone_ready = 1'b1;
    tick();
    chk("tone_on_after_accept", int'(tone_on), 1);
    chk("note_idx_first", int'(note_idx), 2);
    chk("valid_dropped", int'(tone_valid), 0);

    // single key sustained
    bad_on    = 0;
    bad_valid = 0;
    repeat (100) begin
      tick();
      if (!tone_on) bad_on++;
      if (tone_valid) bad_valid++;
    end
    chk("sustain_on_drops", bad_on, 0);
    chk("sustain_valid_seen", bad_valid, 0);
    chk("sustain_handshakes", hs_count, 1);

    // add key 1, stall the resulting LOAD, then reset mid-LOAD
    tone_ready = 1'b0;
    keys       = 8'h06;
    wait_valid(60, "stall_load_reached");
    chk("second_key_period", int'(tone_period), 170263);
    rst  = 1'b1;
    keys = 8'h91;
    tick();
    rst        = 1'b0;
    tone_ready = 1'b1;
    chk("rst_mid_load_valid", int'(tone_valid), 0);
    chk("rst_mid_load_on", int'(tone_on), 0);
    chk("rst_mid_load_keys", int'(active_keys), 0);
    tick();
    chk("idle_after_rst_valid", int'(tone_valid), 0);

    // arpeggio over keys 0, 4, 7 starting from ptr 0
    arp[0] = 3'd0; arp[1] = 3'd4; arp[2] = 3'd7; arp[3] = 3'd0;
    arp[4] = 3'd4; arp[5] = 3'd7; arp[6] = 3'd0;
    for (int i = 0; i < 7; i++) begin
      case (arp[i])
        3'd0:    exp_q.push_back('{PW'(191113), 3'd0});
        3'd4:    exp_q.push_back('{PW'(127553), 3'd4});
        default: exp_q.push_back('{PW'(95557),  3'd7});
      endcase
    end
    for (int s = 0; s < 6; s++) begin
      wait_on(60, "arp_slot_start");
      chk("arp_slot_note", int'(note_idx), int'(arp[s]));
      len = 0;
      while (tone_on && len < 40) begin
        tick();
        len++;
      end
      chk("arp_slot_len", len, 16);
    end
    wait_on(10, "arp_wrap_start");
    chk("arp_wrap_note", int'(note_idx), 0);

    // release the sounding key mid-slot: next held note reloads at once
    tick();
    tick();
    keys = 8'h90;
    exp_q.push_back('{PW'(127553), 3'd4});
    len = 0;
    while (active_keys != 8'h90 && len < 20) begin
      tick();
      len++;
    end
    chk("release_debounced", int'(active_keys), 8'h90);
    chk("release_still_on", int'(tone_on), 1);
    tick();
    chk("release_reload_valid", int'(tone_valid), 1);
    chk("release_reload_period", int'(tone_period), 127553);
    tick();
    chk("release_playing", int'(tone_on), 1);

    // back-pressure: stall LOAD 10 clocks, release all keys meanwhile
    tone_ready = 1'b0;
    wait_valid(40, "bp_load_reached");
    keys      = 8'h00;
    bad_valid = 0;
    seen      = 0;
    repeat (10) begin
      tick();
      if (!tone_valid) bad_valid++;
      if (tone_period != PW'(95557)) seen++;
    end
    chk("bp_valid_stable", bad_valid, 0);
    chk("bp_period_stable", seen, 0);
    chk("bp_keys_released", int'(active_keys), 0);
    exp_q.push_back('{PW'(95557), 3'd7});
    tone_ready = 1'b1;
    tick();
    chk("bp_idle_valid", int'(tone_valid), 0);
    chk("bp_idle_on", int'(tone_on), 0);
    chk("bp_note_idx", int'(note_idx), 7);
    bad_on = 0;
    repeat (5) begin
      tick();
      if (tone_on || tone_valid) bad_on++;
    end
    chk("bp_stays_idle", bad_on, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
